// File: rtl/wb_demux_1x3.sv
// rtl/wb_demux_1x3.sv - one-to-three stream demultiplexer with per-lane holding registers
// Illegal selects are dropped and counted.
module wb_demux_1x3 #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] IN_DATA,
  input  logic [1:0]   IN_SEL,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [N-1:0] A_DATA,
  output logic [N-1:0] B_DATA,
  output logic [N-1:0] C_DATA,
  output logic         A_VALID,
  output logic         B_VALID,
  output logic         C_VALID,
  input  logic         A_READY,
  input  logic         B_READY,
  input  logic         C_READY,
  output logic         ERR_SEL,
  output logic [7:0]   DROP_CNT
);

  logic [N-1:0] r_data [3];
  logic [2:0]   r_valid;
  logic         r_err;
  logic [7:0]   r_drop;

  logic [2:0]   w_lane_rdy;
  logic [3:0]   w_slot_free;
  logic         w_accept;

  assign w_lane_rdy  = {C_READY, B_READY, A_READY};
  // Slot 3 is the drop sink: it can always take a word.
  assign w_slot_free = {1'b1, ~r_valid | w_lane_rdy};
  assign IN_READY    = w_slot_free[IN_SEL];
  assign w_accept    = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        r_data[i] <= '0;
      end
      r_valid <= '0;
      r_err   <= 1'b0;
      r_drop  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_accept && (IN_SEL == 2'(i))) begin
          r_data[i]  <= IN_DATA;
          r_valid[i] <= 1'b1;
        end else if (r_valid[i] && w_lane_rdy[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_accept && (IN_SEL == 2'b11)) begin
        r_err <= 1'b1;
        if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end
    end
  end

  assign A_DATA   = r_data[0];
  assign B_DATA   = r_data[1];
  assign C_DATA   = r_data[2];
  assign A_VALID  = r_valid[0];
  assign B_VALID  = r_valid[1];
  assign C_VALID  = r_valid[2];
  assign ERR_SEL  = r_err;
  assign DROP_CNT = r_drop;

endmodule

// File: tb/tb_wb_demux_1x3.sv
// tb/tb_wb_demux_1x3.sv - directed and randomized bench for wb_demux_1x3
// Lanes are modelled as capacity-one queues plus a last-loaded word.
module tb_wb_demux_1x3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IN_DATA;
  logic [1:0]  IN_SEL;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] A_DATA, B_DATA, C_DATA;
  logic        A_VALID, B_VALID, C_VALID;
  logic        A_READY, B_READY, C_READY;
  logic        ERR_SEL;
  logic [7:0]  DROP_CNT;

  wb_demux_1x3 #(.N(32)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_SEL(IN_SEL), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .C_DATA(C_DATA),
    .A_VALID(A_VALID), .B_VALID(B_VALID), .C_VALID(C_VALID),
    .A_READY(A_READY), .B_READY(B_READY), .C_READY(C_READY),
    .ERR_SEL(ERR_SEL), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] lane_q [3][$];
  logic [31:0] last_word [3];
  logic        m_err;
  int          m_drop;
  logic        seen_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      lane_q[i].delete();
      last_word[i] = 32'h0;
    end
    m_err  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":A_VALID"}, 64'(A_VALID), 64'(lane_q[0].size() != 0));
    chk({tag, ":B_VALID"}, 64'(B_VALID), 64'(lane_q[1].size() != 0));
    chk({tag, ":C_VALID"}, 64'(C_VALID), 64'(lane_q[2].size() != 0));
    chk({tag, ":A_DATA"},  64'(A_DATA),  64'(last_word[0]));
    chk({tag, ":B_DATA"},  64'(B_DATA),  64'(last_word[1]));
    chk({tag, ":C_DATA"},  64'(C_DATA),  64'(last_word[2]));
    chk({tag, ":ERR_SEL"}, 64'(ERR_SEL), 64'(m_err));
    chk({tag, ":DROP_CNT"}, 64'(DROP_CNT), 64'(m_drop));
  endtask

  // One clock: drive, check IN_READY, advance model, sample after the edge.
  task automatic step(input string tag, input logic rst, input logic v, input logic [1:0] sel,
                      input logic [31:0] d, input logic [2:0] rdy);
    logic exp_rdy;
    RST = rst; IN_VALID = v; IN_SEL = sel; IN_DATA = d;
    {C_READY, B_READY, A_READY} = rdy;
    #1;
    exp_rdy = (sel == 2'b11) ? 1'b1 : ((lane_q[sel].size() == 0) || rdy[sel]);
    seen_ready = IN_READY;
    chk({tag, ":IN_READY"}, 64'(IN_READY), 64'(exp_rdy));
    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++)
        if (lane_q[i].size() != 0 && rdy[i]) void'(lane_q[i].pop_front());
      if (v && exp_rdy) begin
        if (sel == 2'b11) begin
          m_err  = 1'b1;
          m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
        end else begin
          lane_q[sel].push_back(d);
          last_word[sel] = d;
        end
      end
    end
    @(posedge CLK);
    #1;
    check_state(tag);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_SEL = 2'b00; IN_DATA = 32'h0;
    A_READY = 1'b0; B_READY = 1'b0; C_READY = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check_state("reset");
    chk("reset:IN_READY", 64'(IN_READY), 64'(1));

    // Basic dispatch to lane B
    step("disp0", 0, 1, 2'b01, 32'hDEADBEEF, 3'b010);
    chk("disp:B_DATA", 64'(B_DATA), 64'h0000_0000_DEAD_BEEF);
    chk("disp:B_VALID", 64'(B_VALID), 64'(1));
    step("disp1", 0, 0, 2'b01, 32'h0, 3'b010);
    chk("disp:B_VALID_low", 64'(B_VALID), 64'(0));

    // Backpressure on A; C still flows
    step("bp0", 0, 1, 2'b00, 32'h1, 3'b000);
    step("bp1", 0, 1, 2'b00, 32'h2, 3'b000);
    chk("bp:in_ready_low", 64'(seen_ready), 64'(0));
    chk("bp:A_held", 64'(A_DATA), 64'(1));
    step("bp2", 0, 1, 2'b10, 32'h3, 3'b100);
    chk("bp:C_got3", 64'(C_DATA), 64'(3));
    step("bp3", 0, 1, 2'b00, 32'h2, 3'b001);
    chk("bp:A_now2", 64'(A_DATA), 64'(2));
    step("bp4", 0, 0, 2'b00, 32'h0, 3'b001);
    chk("bp:A_empty", 64'(A_VALID), 64'(0));

    // Streaming lane C
    for (int i = 0; i < 4; i++) begin
      step("stream", 0, 1, 2'b10, 32'(i), 3'b100);
      chk("stream:C_DATA", 64'(C_DATA), 64'(i));
      chk("stream:C_VALID", 64'(C_VALID), 64'(1));
    end
    step("stream_end", 0, 0, 2'b10, 32'h0, 3'b100);

    // Illegal select saturation
    for (int i = 0; i < 300; i++) step("illegal", 0, 1, 2'b11, $urandom, 3'($urandom));
    chk("illegal:DROP_FF", 64'(DROP_CNT), 64'hFF);
    chk("illegal:ERR", 64'(ERR_SEL), 64'(1));
    step("illegal_idle", 0, 0, 2'b11, 32'h5, 3'b111);
    chk("illegal:DROP_hold", 64'(DROP_CNT), 64'hFF);

    // Reset mid-stall
    step("mr0", 0, 1, 2'b00, 32'hAAAA, 3'b000);
    step("mr1", 0, 1, 2'b01, 32'hBBBB, 3'b000);
    step("mr2", 1, 1, 2'b00, 32'hCCCC, 3'b000);
    chk("mr:A_VALID", 64'(A_VALID), 64'(0));
    chk("mr:B_VALID", 64'(B_VALID), 64'(0));
    chk("mr:ERR", 64'(ERR_SEL), 64'(0));
    chk("mr:DROP", 64'(DROP_CNT), 64'(0));
    step("mr3", 0, 0, 2'b00, 32'h0, 3'b111);
    chk("mr:no_delivery", 64'(A_VALID), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(99) < 2), ($urandom_range(99) < 75),
           2'($urandom_range(3)), $urandom, 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
